// File: rtl/hamming_decoder.sv
// hamming_decoder
//   Serial-in Hamming(12,8) single-error-correcting decoder for the FSK
//   receive path. Codewords arrive MSB first (c[11] first), framed by
//   frame_start on the first qualified bit. Each complete codeword is checked,
//   a single-bit error is corrected, and the 8-bit payload is delivered
//   with status flags one cycle after the 12th bit is sampled.
//
//   Bit layout (position p = 12 - i for bit c[i]):
//     c11=p1 c10=p2 c9=d7 c8=p4 c7=d6 c6=d5 c5=d4 c4=p8 c3..c0=d3..d0
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         asynchronous active-high reset
//   bit_i         received hard-decision bit
//   bit_valid_i   bit_i is qualified this cycle
//   frame_start_i qualified bit is c[11] of a new codeword
//   cnt_clr_i     synchronous clear of both error counters
//   data_o        decoded payload d[7:0], held between pulses
//   out_valid_o   one-cycle pulse: data_o and flags valid
//   err_corr_o    single error corrected (qualified by out_valid_o)
//   err_uncorr_o  invalid syndrome 13..15 (qualified by out_valid_o)
//   busy_o        a frame is partially received
//   corr_cnt_o    saturating count of corrected frames
//   uncorr_cnt_o  saturating count of uncorrectable frames
//
// State table
//   IDLE   | waiting for a qualified bit with frame_start
//   SHIFT  | collecting codeword bits 2..12
//   DECODE | full codeword held; outputs registered on the next edge

module hamming_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             cnt_clr,
  output logic [7:0]       data_out,
  output logic             out_valid,
  output logic             err_corr,
  output logic             err_uncorr,
  output logic             busy,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [11:0]      sr_q, sr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             corr_q, corr_d;
  logic             uncorr_q, uncorr_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  logic             start_bit;
  logic [3:0]       syn;
  logic [7:0]       raw_data;
  logic [7:0]       fix_mask;
  logic             syn_corr;
  logic             syn_uncorr;

  assign start_bit = bit_valid & frame_start;

  // Syndrome over the held codeword; only meaningful in DECODE.
  always_comb begin
    syn[0] = sr_q[11] ^ sr_q[9] ^ sr_q[7] ^ sr_q[5] ^ sr_q[3] ^ sr_q[1];
    syn[1] = sr_q[10] ^ sr_q[9] ^ sr_q[6] ^ sr_q[5] ^ sr_q[2] ^ sr_q[1];
    syn[2] = sr_q[8]  ^ sr_q[7] ^ sr_q[6] ^ sr_q[5] ^ sr_q[0];
    syn[3] = sr_q[4]  ^ sr_q[3] ^ sr_q[2] ^ sr_q[1] ^ sr_q[0];
  end

  assign raw_data = {sr_q[9], sr_q[7:5], sr_q[3:0]};

  // Only data positions need a flip mask; syndromes pointing at parity
  // positions (1, 2, 4, 8) still count as corrections but leave the
  // payload untouched.
  always_comb begin
    fix_mask   = 8'h00;
    syn_corr   = 1'b0;
    syn_uncorr = 1'b0;
    case (syn)
      4'd0:  ;
      4'd3:  fix_mask = 8'h80;
      4'd5:  fix_mask = 8'h40;
      4'd6:  fix_mask = 8'h20;
      4'd7:  fix_mask = 8'h10;
      4'd9:  fix_mask = 8'h08;
      4'd10: fix_mask = 8'h04;
      4'd11: fix_mask = 8'h02;
      4'd12: fix_mask = 8'h01;
      default: ;
    endcase
    if (syn >= 4'd13) begin
      syn_uncorr = 1'b1;
    end else if (syn != 4'd0) begin
      syn_corr = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    corr_d       = 1'b0;
    uncorr_d     = 1'b0;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;

    case (state_q)
      IDLE: begin
        if (start_bit) begin
          sr_d    = {11'd0, bit_in};
          cnt_d   = 4'd1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (start_bit) begin
          // A new marker abandons the partial frame silently.
          sr_d  = {11'd0, bit_in};
          cnt_d = 4'd1;
        end else if (bit_valid) begin
          sr_d  = {sr_q[10:0], bit_in};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd11) begin
            state_d = DECODE;
          end
        end
      end

      DECODE: begin
        data_d   = raw_data ^ fix_mask;
        valid_d  = 1'b1;
        corr_d   = syn_corr;
        uncorr_d = syn_uncorr;

        if (syn_corr && corr_cnt_q != CNT_MAX) begin
          corr_cnt_d = corr_cnt_q + 1'b1;
        end
        if (syn_uncorr && uncorr_cnt_q != CNT_MAX) begin
          uncorr_cnt_d = uncorr_cnt_q + 1'b1;
        end

        if (start_bit) begin
          sr_d    = {11'd0, bit_in};
          cnt_d   = 4'd1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      corr_q       <= 1'b0;
      uncorr_q     <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      corr_q       <= corr_d;
      uncorr_q     <= uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign data_out   = data_q;
  assign out_valid  = valid_q;
  assign err_corr   = corr_q;
  assign err_uncorr = uncorr_q;
  assign busy       = (state_q == SHIFT);
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: a default-width instance plus a
// CNT_W=2 instance sharing the same stimulus for the saturation case.

module tb_hamming_decoder;

  logic clk = 1'b0;
  logic rst;
  logic bit_in, bit_valid, frame_start, cnt_clr;

  logic [7:0] data_out;
  logic       out_valid, err_corr, err_uncorr, busy;
  logic [7:0] corr_cnt, uncorr_cnt;

  logic [7:0] data_out2;
  logic       out_valid2, err_corr2, err_uncorr2, busy2;
  logic [1:0] corr_cnt2, uncorr_cnt2;

  always #5 clk = ~clk;

  hamming_decoder dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .cnt_clr(cnt_clr),
    .data_out(data_out), .out_valid(out_valid), .err_corr(err_corr),
    .err_uncorr(err_uncorr), .busy(busy),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  hamming_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .cnt_clr(cnt_clr),
    .data_out(data_out2), .out_valid(out_valid2), .err_corr(err_corr2),
    .err_uncorr(err_uncorr2), .busy(busy2),
    .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor, sampled 1 time unit after each rising edge.
  int         cyc = 0;
  int         pulses = 0;
  int         last_cyc = 0, prev_cyc = 0;
  logic [7:0] last_data = 8'h00, prev_data = 8'h00;
  logic       last_corr = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (out_valid === 1'b1) begin
      pulses    = pulses + 1;
      prev_cyc  = last_cyc;
      prev_data = last_data;
      last_cyc  = cyc;
      last_data = data_out;
      last_corr = err_corr;
    end
  end

  task automatic drive(input logic b, input logic fs);
    @(negedge clk);
    bit_in      = b;
    bit_valid   = 1'b1;
    frame_start = fs;
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    bit_in      = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [11:0] w, input int gap);
    for (int i = 11; i >= 0; i--) begin
      drive(w[i], i == 11);
      if (i > 0) repeat (gap) idle_cyc();
    end
  endtask

  // First negedge is the DECODE cycle; returns at the negedge where the
  // registered outputs of the frame are visible.
  task automatic finish_frame(input logic clr);
    @(negedge clk);
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    cnt_clr     = clr;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  initial begin
    int p0;
    logic [11:0] w;

    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {err_corr, err_uncorr}, 0);
    chk("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
    rst = 1'b0;

    // Clean codeword with exact latency
    send_word(12'hE45, 0);
    chk("busy_mid", busy, 1);
    @(negedge clk);
    bit_valid = 1'b0; frame_start = 1'b0;
    chk("early_valid", out_valid, 0);
    @(negedge clk);
    chk("clean_valid", out_valid, 1);
    chk("clean_data", data_out, 8'hA5);
    chk("clean_flags", {err_corr, err_uncorr}, 0);
    chk("clean_busy", busy, 0);
    @(negedge clk);
    chk("pulse_width", out_valid, 0);
    chk("data_hold", data_out, 8'hA5);

    // d7 flipped, S=3
    send_word(12'hC45, 0);
    finish_frame(1'b0);
    chk("s3_data", data_out, 8'hA5);
    chk("s3_corr", {err_corr, err_uncorr}, 2'b10);
    chk("s3_cnt", corr_cnt, 1);

    // p1 flipped, S=1, with bit_valid gaps
    send_word(12'h645, 2);
    finish_frame(1'b0);
    chk("s1_valid", out_valid, 1);
    chk("s1_data", data_out, 8'hA5);
    chk("s1_corr", err_corr, 1);
    chk("s1_cnt", corr_cnt, 2);

    // d0 flipped, S=12
    send_word(12'hE44, 0);
    finish_frame(1'b0);
    chk("s12_data", data_out, 8'hA5);
    chk("s12_corr", err_corr, 1);
    chk("s12_cnt", corr_cnt, 3);

    // c11 and c0 flipped, S=13
    send_word(12'h644, 0);
    finish_frame(1'b0);
    chk("s13_data", data_out, 8'hA4);
    chk("s13_flags", {err_corr, err_uncorr}, 2'b01);
    chk("s13_ucnt", uncorr_cnt, 1);
    chk("s13_ccnt", corr_cnt, 3);

    // Partial frame abandoned by a new marker
    p0 = pulses;
    w = 12'hE45;
    for (int i = 11; i >= 6; i--) drive(w[i], i == 11);
    send_word(12'h000, 0);
    finish_frame(1'b0);
    chk("restart_data", data_out, 8'h00);
    chk("restart_flags", {err_corr, err_uncorr}, 0);
    idle_cyc();
    chk("restart_pulses", pulses - p0, 1);

    // Back-to-back, new marker in the DECODE cycle
    p0 = pulses;
    send_word(12'hE45, 0);
    send_word(12'hC45, 0);
    finish_frame(1'b0);
    idle_cyc();
    chk("b2b_pulses", pulses - p0, 2);
    chk("b2b_spacing", last_cyc - prev_cyc, 12);
    chk("b2b_data0", prev_data, 8'hA5);
    chk("b2b_data1", last_data, 8'hA5);
    chk("b2b_corr1", last_corr, 1);
    chk("b2b_cnt", corr_cnt, 4);

    // Counter clear and saturation
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    chk("clr_cnts", {corr_cnt, uncorr_cnt}, 0);
    chk("clr_cnts2", {corr_cnt2, uncorr_cnt2}, 0);
    for (int n = 0; n < 5; n++) begin
      send_word(12'hC45, 0);
      finish_frame(1'b0);
    end
    chk("sat_cnt8", corr_cnt, 5);
    chk("sat_cnt2", corr_cnt2, 3);
    chk("sat_data2", data_out2, 8'hA5);
    send_word(12'hC45, 0);
    finish_frame(1'b1);
    chk("clr_pri_valid", out_valid, 1);
    chk("clr_pri_corr", err_corr, 1);
    chk("clr_pri_cnt8", corr_cnt, 0);
    chk("clr_pri_cnt2", corr_cnt2, 0);

    // Reset mid-frame
    send_word(12'h644, 0);
    finish_frame(1'b0);
    chk("pre_rst_ucnt", uncorr_cnt, 1);
    p0 = pulses;
    w = 12'hC45;
    for (int i = 11; i >= 6; i--) drive(w[i], i == 11);
    @(negedge clk);
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnts", {corr_cnt, uncorr_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 5; i >= 0; i--) drive(w[i], 1'b0);
    repeat (4) idle_cyc();
    chk("mid_rst_pulses", pulses - p0, 0);
    chk("mid_rst_idle", busy, 0);
    chk("mid_rst_data2", data_out, 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
